// File: rtl/pixel_adc_readout.sv
// Two-pixel single-slope ADC back end: ramp capture, frame erase, readout.
// Define PIXEL_CMP_SYNC_EN to pass each comparator bit through a 2-flop synchronizer.
module pixel_adc_readout #(
  parameter int DW      = 8,
  parameter int CNT_MAX = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          erase,
  input  logic          expose,
  input  logic          convert,
  input  logic          read1,
  input  logic          read2,
  input  logic [1:0]    cmp,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, CONV, DONE, RD1, RD2
  } state_t;

  localparam logic [DW-1:0] MAXV = DW'(CNT_MAX);

  state_t        state, nxt;
  logic [DW-1:0] cnt;
  logic [DW-1:0] code0, code1;
  logic [1:0]    latched, ovf_f;
  logic [1:0]    cmp_eff, hit;

`ifdef PIXEL_CMP_SYNC_EN
  logic [1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= cmp;
      sync2 <= sync1;
    end
  end

  assign cmp_eff = sync2;
`else
  assign cmp_eff = cmp;
`endif

  assign hit = (state == CONV) ? (cmp_eff & ~latched) : 2'b00;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (erase)        nxt = CLEAR;
        else if (convert) nxt = CONV;
        else if (read1)   nxt = RD1;
        else if (read2)   nxt = RD2;
        else if (expose)  nxt = IDLE;
      end
      CLEAR: if (!erase) nxt = IDLE;
      CONV: begin
        if (erase)         nxt = CLEAR;
        else if (!convert) nxt = DONE;
      end
      DONE: nxt = IDLE;
      RD1, RD2: begin
        // back-to-back reads hop straight across without an idle gap
        if (erase)        nxt = CLEAR;
        else if (convert) nxt = CONV;
        else if (read1)   nxt = RD1;
        else if (read2)   nxt = RD2;
        else              nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      code0   <= '0;
      code1   <= '0;
      latched <= '0;
      ovf_f   <= '0;
    end else begin
      state <= nxt;
      if (nxt == CLEAR) begin
        cnt     <= '0;
        code0   <= '0;
        code1   <= '0;
        latched <= '0;
        ovf_f   <= '0;
      end else if (state != CONV && nxt == CONV) begin
        cnt     <= '0;
        latched <= '0;
        ovf_f   <= '0;
      end else if (state == CONV) begin
        if (hit[0]) code0 <= cnt;
        if (hit[1]) code1 <= cnt;
        latched <= latched | hit;
        if (cnt != MAXV) cnt <= cnt + 1'b1;
      end else if (state == DONE) begin
        if (!latched[0]) begin
          code0    <= MAXV;
          ovf_f[0] <= 1'b1;
        end
        if (!latched[1]) begin
          code1    <= MAXV;
          ovf_f[1] <= 1'b1;
        end
      end
    end
  end

  // outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy       <= (nxt == CONV);
      data_valid <= (nxt == RD1) || (nxt == RD2);
      if (nxt == RD1) begin
        data_out <= code0;
        ovf      <= ovf_f[0];
      end else if (nxt == RD2) begin
        data_out <= code1;
        ovf      <= ovf_f[1];
      end else begin
        data_out <= '0;
        ovf      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_adc_readout.sv
// Directed bench for pixel_adc_readout: capture, overflow, glitch, abort, reset.
// Expected codes shift by 2 when built with PIXEL_CMP_SYNC_EN.
module tb_pixel_adc_readout;

`ifdef PIXEL_CMP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NEVER = 9999;

  logic       clk = 1'b0;
  logic       reset, erase, expose, convert, read1, read2;
  logic [1:0] cmp;
  logic [7:0] data_out;
  logic       data_valid, ovf, busy;

  int checks = 0;
  int errors = 0;

  pixel_adc_readout #(.DW(8), .CNT_MAX(255)) dut (
    .clk(clk), .reset(reset), .erase(erase),
    .expose(expose), .convert(convert),
    .read1(read1), .read2(read2), .cmp(cmp),
    .data_out(data_out), .data_valid(data_valid),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_erase(input int n);
    erase = 1'b1;
    repeat (n) tick();
    erase = 1'b0;
    tick();
  endtask

  // cmp[0] high in [a0,b0) or from c0; cmp[1] high from a1
  task automatic conv(input int n, input int a0, input int b0,
                      input int c0, input int a1);
    convert = 1'b1;
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_on", busy, 1);
      cmp[0] = ((k >= a0) && (k < b0)) || (k >= c0);
      cmp[1] = (k >= a1);
      if (k == n - 1) convert = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    cmp = 2'b00;
    check("busy_off", busy, 0);
    tick();
  endtask

  task automatic conv_stop(input int stop, input int a0, input bit rst);
    convert = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= stop; k++) begin
      @(negedge clk);
      cmp[0] = (k >= a0);
      if (k == stop) begin
        if (rst) reset = 1'b1;
        else     erase = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check(rst ? "rst_busy" : "abort_busy", busy, 0);
    cmp = 2'b00;
    convert = 1'b0;
    reset = 1'b0;
    erase = 1'b0;
    tick();
  endtask

  task automatic rd(input bit sel, input int code, input int ov);
    check("rd_pre_valid", data_valid, 0);
    if (sel) read2 = 1'b1;
    else     read1 = 1'b1;
    tick();
    check(sel ? "rd2_valid" : "rd1_valid", data_valid, 1);
    check(sel ? "rd2_code" : "rd1_code", data_out, code);
    check(sel ? "rd2_ovf" : "rd1_ovf", ovf, ov);
    tick();
    check(sel ? "rd2_code_hold" : "rd1_code_hold", data_out, code);
    read1 = 1'b0;
    read2 = 1'b0;
    tick();
    check("rd_valid_off", data_valid, 0);
    check("rd_data_off", data_out, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    erase = 1'b0;
    expose = 1'b0;
    convert = 1'b0;
    read1 = 1'b0;
    read2 = 1'b0;
    cmp = 2'b00;
    repeat (2) tick();
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // frame 1: trips at 37 and 200
    do_erase(5);
    expose = 1'b1;
    repeat (3) tick();
    expose = 1'b0;
    check("expose_busy", busy, 0);
    conv(256, 37, NEVER, NEVER, 200);
    rd(1'b0, 37 + LAT, 0);
    rd(1'b1, 200 + LAT, 0);
    rd(1'b0, 37 + LAT, 0);

    // back-to-back read1 -> read2
    read1 = 1'b1;
    tick();
    check("b2b_code0", data_out, 37 + LAT);
    read1 = 1'b0;
    read2 = 1'b1;
    tick();
    check("b2b_valid", data_valid, 1);
    check("b2b_code1", data_out, 200 + LAT);
    read2 = 1'b0;
    tick();
    check("b2b_off", data_valid, 0);

    // frame 2: pixel 0 tripped from start, pixel 1 never
    do_erase(2);
    conv(256, 0, NEVER, NEVER, NEVER);
    rd(1'b0, 0 + LAT, 0);
    rd(1'b1, 255, 1);

    // frame 3: glitchy pixel 0 keeps first trip
    do_erase(2);
    conv(100, 10, 11, 50, NEVER);
    rd(1'b0, 10 + LAT, 0);
    rd(1'b1, 255, 1);

    // reset mid-conversion at counter 100
    conv_stop(100, 20, 1'b1);
    rd(1'b0, 0, 0);
    rd(1'b1, 0, 0);

    // frame with pixel 1 overflow, then erase abort at cycle 60
    conv(50, NEVER, NEVER, NEVER, NEVER);
    rd(1'b1, 255, 1);
    conv_stop(60, 5, 1'b0);
    rd(1'b0, 0, 0);
    rd(1'b1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
